// File: rtl/apb_mig_bridge.sv
// APB slave to MIG native application interface bridge.
// Each single APB read or write becomes one MIG command (plus one write-data beat for
// writes). The APB word is steered onto its byte lane within the wider MIG word.
// Illegal addresses, a MIG that stops responding, and read data that arrives after a
// timeout are all handled without hanging the APB bus.
module apb_mig_bridge #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int MIG_ADDR_WIDTH = 27,
    parameter int MIG_DATA_WIDTH = 128,
    parameter int APP_ADDR_SHIFT = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        pclk,
    input  logic                        presetn,
    input  logic                        psel,
    input  logic                        penable,
    input  logic                        pwrite,
    input  logic [APB_ADDR_WIDTH-1:0]   paddr,
    input  logic [APB_DATA_WIDTH-1:0]   pwdata,
    input  logic [APB_DATA_WIDTH/8-1:0] pstrb,
    output logic [APB_DATA_WIDTH-1:0]   prdata,
    output logic                        pready,
    output logic                        pslverr,
    output logic [MIG_ADDR_WIDTH-1:0]   app_addr,
    output logic [2:0]                  app_cmd,
    output logic                        app_en,
    input  logic                        app_rdy,
    output logic [MIG_DATA_WIDTH-1:0]   app_wdf_data,
    output logic [MIG_DATA_WIDTH/8-1:0] app_wdf_mask,
    output logic                        app_wdf_wren,
    output logic                        app_wdf_end,
    input  logic                        app_wdf_rdy,
    input  logic [MIG_DATA_WIDTH-1:0]   app_rd_data,
    input  logic                        app_rd_data_valid
);
    localparam int AB        = APB_DATA_WIDTH / 8;
    localparam int MB        = MIG_DATA_WIDTH / 8;
    localparam int LANES     = MB / AB;
    localparam int OFS       = $clog2(MB);
    localparam int AOFS      = $clog2(AB);
    localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW        = $clog2(TIMEOUT_CYCLES + 2);
    localparam int WORD_BITS = MIG_ADDR_WIDTH - APP_ADDR_SHIFT;

    typedef enum logic [2:0] {IDLE, WR, RD_CMD, RD_DATA, RESP} state_t;

    state_t                    state, state_next;
    logic [APB_ADDR_WIDTH-1:0] word;
    logic [LW-1:0]             lane, lane_q;
    logic                      reject, request, busy, timeout;
    logic                      cmd_fin, wdf_fin, rd_hit;
    logic [CW-1:0]             tcount;
    logic                      orphan, err;
    logic [MIG_ADDR_WIDTH-1:0] addr_next;
    logic [MB-1:0]             mask_next;

    // Address decode, legality checks and per-cycle handshake status
    always_comb begin
        word      = paddr >> OFS;
        lane      = LW'((paddr >> AOFS) & APB_ADDR_WIDTH'(LANES - 1));
        reject    = ((paddr & APB_ADDR_WIDTH'(AB - 1)) != '0) || ((word >> WORD_BITS) != '0);
        addr_next = MIG_ADDR_WIDTH'({{MIG_ADDR_WIDTH{1'b0}}, word} << APP_ADDR_SHIFT);
        mask_next = '1;
        for (int l = 0; l < LANES; l++) begin
            if (lane == LW'(l)) mask_next[l*AB +: AB] = ~pstrb;
        end
        request = psel && penable;
        busy    = (state == WR) || (state == RD_CMD) || (state == RD_DATA);
        timeout = busy && (tcount >= CW'(TIMEOUT_CYCLES - 1));
        // A channel counts as finished once its valid has dropped or is being accepted now
        cmd_fin = !app_en || app_rdy;
        wdf_fin = !app_wdf_wren || app_wdf_rdy;
        rd_hit  = app_rd_data_valid && !orphan;
    end

    // Next-state selection; a completed handshake wins over a simultaneous timeout
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (request) state_next = reject ? RESP : (pwrite ? WR : RD_CMD);
            WR:      if ((cmd_fin && wdf_fin) || timeout) state_next = RESP;
            RD_CMD:  if (app_rdy) state_next = RD_DATA;
                     else if (timeout) state_next = RESP;
            RD_DATA: if (rd_hit || timeout) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state <= IDLE;
        else          state <= state_next;
    end

    // MIG request/data registers, timeout counter, orphan tracking and APB read data
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            app_addr     <= '0;
            app_cmd      <= 3'b001;
            app_en       <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_mask <= '1;
            app_wdf_wren <= 1'b0;
            prdata       <= '0;
            lane_q       <= '0;
            tcount       <= '0;
            orphan       <= 1'b0;
            err          <= 1'b0;
        end else begin
            // Data from a read that already timed out is dropped wherever it shows up
            if (app_rd_data_valid && orphan) orphan <= 1'b0;
            case (state)
                IDLE: if (request) begin
                    err <= reject;
                    if (!reject) begin
                        tcount   <= '0;
                        app_addr <= addr_next;
                        lane_q   <= lane;
                        app_en   <= 1'b1;
                        if (pwrite) begin
                            app_cmd      <= 3'b000;
                            app_wdf_data <= {LANES{pwdata}};
                            app_wdf_mask <= mask_next;
                            app_wdf_wren <= 1'b1;
                        end else begin
                            app_cmd <= 3'b001;
                        end
                    end
                end
                WR: begin
                    tcount <= tcount + CW'(1);
                    if (app_rdy)     app_en       <= 1'b0;
                    if (app_wdf_rdy) app_wdf_wren <= 1'b0;
                    if (timeout && !(cmd_fin && wdf_fin)) begin
                        app_en       <= 1'b0;
                        app_wdf_wren <= 1'b0;
                        err          <= 1'b1;
                    end
                end
                RD_CMD: begin
                    tcount <= tcount + CW'(1);
                    if (app_rdy) begin
                        app_en <= 1'b0;
                    end else if (timeout) begin
                        app_en <= 1'b0;
                        err    <= 1'b1;
                    end
                end
                RD_DATA: begin
                    tcount <= tcount + CW'(1);
                    if (rd_hit) begin
                        prdata <= app_rd_data[lane_q*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                    end else if (timeout) begin
                        // The command is already in the MIG, so its data is still owed
                        err    <= 1'b1;
                        orphan <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pready      = (state == RESP);
    assign pslverr     = (state == RESP) && err;
    assign app_wdf_end = app_wdf_wren;

endmodule

// File: doc/apb_mig_bridge.md
Name: apb_mig_bridge

Overview:
- APB slave that converts single APB reads and writes into accesses on the MIG native application interface (app_* command, write-data and read-data channels).
- Generalises the fixed 32-bit-APB / 128-bit-MIG typing:
  - APB data width, MIG data width and address mapping are parameters.
  - Adds byte-lane steering with write masking.
  - Adds independent command and write-data handshakes.
  - Adds address range and alignment error checking, a timeout with PSLVERR, and orphaned-read recovery.
- Sits between the system APB interconnect and the MIG user interface, in the MIG ui_clk domain.

Parameters:
- APB_ADDR_WIDTH, 32, APB address width.
- APB_DATA_WIDTH, 32, APB data width; power of two, >= 8.
- MIG_ADDR_WIDTH, 27, app_addr width.
- MIG_DATA_WIDTH, 128, app_wdf_data/app_rd_data width; power-of-two multiple of APB_DATA_WIDTH.
- APP_ADDR_SHIFT, 3, left shift applied to the MIG word index to form app_addr (column units per MIG word).
- TIMEOUT_CYCLES, 1024, maximum cycles spent waiting on MIG per transfer; >= 2.

Ports:
- pclk  in  1  clock (MIG ui_clk).
- presetn  in  1  asynchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  APB direction, 1 = write.
- paddr  in  APB_ADDR_WIDTH  byte address.
- pwdata  in  APB_DATA_WIDTH  write data.
- pstrb  in  APB_DATA_WIDTH/8  write byte strobes.
- prdata  out  APB_DATA_WIDTH  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  error, valid with pready.
- app_addr  out  MIG_ADDR_WIDTH  MIG command address.
- app_cmd  out  3  MIG command: 000 = write, 001 = read.
- app_en  out  1  command valid.
- app_rdy  in  1  command accepted.
- app_wdf_data  out  MIG_DATA_WIDTH  write data.
- app_wdf_mask  out  MIG_DATA_WIDTH/8  byte mask, 1 = do not write.
- app_wdf_wren  out  1  write data valid.
- app_wdf_end  out  1  last beat; tied equal to app_wdf_wren.
- app_wdf_rdy  in  1  write data accepted.
- app_rd_data  in  MIG_DATA_WIDTH  read data.
- app_rd_data_valid  in  1  read data valid.

Behaviour:
- Derived constants:
  - AB = APB_DATA_WIDTH/8; MB = MIG_DATA_WIDTH/8.
  - LANES = MB/AB; OFS = log2(MB).
- Address mapping:
  - lane = paddr[OFS-1:log2(AB)].
  - word = paddr >> OFS.
  - app_addr = (word << APP_ADDR_SHIFT), truncated to MIG_ADDR_WIDTH.
- Errors, decided in IDLE with no MIG access issued:
  - Misaligned: paddr[log2(AB)-1:0] != 0.
  - Out of range: word >= 2^(MIG_ADDR_WIDTH-APP_ADDR_SHIFT).
  - Either error -> RESP with pslverr = 1.
- Reset values:
  - pready, pslverr, app_en, app_wdf_wren = 0; prdata = 0; app_cmd = 001.
  - app_addr, app_wdf_data = 0; app_wdf_mask = all 1; state = IDLE; timeout counter = 0; orphan = 0.
- States: IDLE, WR, RD_CMD, RD_DATA, RESP.
- IDLE:
  - psel & penable & legal & pwrite -> WR.
  - Register app_addr and app_cmd = 000.
  - app_wdf_data = pwdata replicated on all lanes.
  - app_wdf_mask = all 1 except lane bytes, which take ~pstrb.
  - Assert app_en and app_wdf_wren from the next cycle.
  - pstrb = 0 is legal: mask all 1, write still issued.
- WR:
  - app_en drops the cycle after the sampled app_en & app_rdy.
  - app_wdf_wren drops the cycle after the sampled app_wdf_wren & app_wdf_rdy.
  - The two handshakes complete in any order or together.
  - Both done -> RESP, pslverr = 0.
- IDLE read: psel & penable & legal & ~pwrite -> RD_CMD, app_cmd = 001, app_en = 1.
- RD_CMD: app_en & app_rdy -> RD_DATA, app_en = 0.
- RD_DATA:
  - On app_rd_data_valid: if orphan = 1, clear orphan and keep waiting.
  - Otherwise prdata = app_rd_data lane slice -> RESP.
- Timeout:
  - Counter clears on entry to WR/RD_CMD and increments each cycle in WR/RD_CMD/RD_DATA.
  - Reaching TIMEOUT_CYCLES -> RESP with pslverr = 1; app_en and app_wdf_wren deasserted.
  - If the timeout occurs after the read command was accepted (RD_DATA), set orphan = 1.
  - app_rd_data_valid seen outside RD_DATA while orphan = 1 clears orphan and the data is discarded.
- RESP:
  - pready = 1 for exactly one cycle, then IDLE.
  - prdata holds until the next successful read; prdata is unchanged on an error.
- pready = 0 in all other states, so there is at least one wait state per transfer.
- psel dropped mid-transfer (protocol violation): the MIG transaction still completes, pready still pulses.
- presetn asserted mid-transfer: immediate return to reset values, orphan cleared; the MIG is assumed reset together.

Test Plan:
- Write, default params, paddr = 0x0000_0014, pwdata = 0xDEAD_BEEF, pstrb = 0xF, app_rdy = app_wdf_rdy = 1:
  - app_addr = 0x8, app_cmd = 000.
  - app_wdf_mask = 0xFF0F; DEADBEEF on every lane.
  - pready after 3 cycles, pslverr = 0.
- Read, paddr = 0x18, app_rd_data lane2 = 0x1234_5678, valid 5 cycles after app_rdy:
  - prdata = 0x1234_5678, app_cmd = 001, one pready pulse.
- Split write handshake, app_wdf_rdy high 4 cycles before app_rdy:
  - app_wdf_wren drops first, app_en held until app_rdy; single pready afterwards.
- paddr = 0x2, and separately paddr = 0x1000_0000 -> pslverr = 1 with no app_en or app_wdf_wren pulse.
- Read with app_rd_data_valid withheld, TIMEOUT_CYCLES = 16:
  - pslverr = 1 at timeout.
  - Late valid discarded; next read returns its own data.
- presetn low during WR with app_rdy = 0 -> all outputs at reset values; the next transfer completes normally.
